uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Wishbone-mapped UART receiver, the receive side of the SoC serial port.
//  - 16x oversampling, 8N1 frames, LSB first.
//  - Received bytes are buffered in a small FIFO and read by the CPU over the dbus.
//  - The decoded chip select (adr[31:24]) follows the existing peripheral scheme.
// PARAMETERS
//  ADDR    0  chip-select value compared against wb_dbus_adr[31:31-AWIDTH+1]
//  AWIDTH  8  width of the chip-select address field
//  DEPTH   4  receive FIFO depth in bytes; power of 2, >= 2
// PORTS
//  wb_clk       in   1   system clock; the only clock
//  wb_rst       in   1   synchronous, active-high reset
//  wb_dbus_adr  in   32  bus address; [31:24] chip select, [2] register select
//  wb_dbus_dat  in   32  write data (status flag clear)
//  wb_dbus_sel  in   4   byte select; ignored
//  wb_dbus_we   in   1   write enable
//  wb_dbus_cyc  in   1   bus cycle
//  rdt          out  32  read data; 0 when not selected
//  ack          out  1   single-cycle bus acknowledge
//  baud16_en    in   1   one-cycle strobe at 16x the baud rate
//  rx           in   1   asynchronous serial input, idle high
//  rx_ready     out  1   FIFO not empty
//  rx_err       out  1   overrun | frame_err
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, overrun=frame_err=0, rdt=0, ack=0, rx_ready=0.
//         Synchroniser flops reset to 1. Reset mid-frame discards the partial byte.
//  Sync: rx passes through 2 flops; all logic uses the synced value rxs.
//  Tick counter: 4 bits. Advances only on baud16_en.
//  FSM (transitions only on baud16_en cycles):
//   IDLE  : rxs==0 -> START, tick=0.
//   START : at tick==7, rxs==0 -> DATA, tick=0, bit=0; rxs==1 -> IDLE (glitch rejected).
//   DATA  : at tick==15, shift in rxs at bit position; bit 7 done -> STOP.
//   STOP  : at tick==15:
//           rxs==1 -> push byte, go IDLE.
//           rxs==0 -> frame_err=1, byte dropped, go BREAK.
//   BREAK : wait for rxs==1, then IDLE.
//  FIFO:
//   - Push when full: byte dropped, overrun=1.
//   - Pop by bus read of DATA.
//   - Push and pop in the same cycle are both honoured, including when full (no overrun).
//   - Pointers are log2(DEPTH)+1 bits and wrap naturally.
//  Bus:
//   - cyc = wb_dbus_cyc & (adr field==ADDR).
//   - ack pulses 1 for exactly one cycle, registered the cycle after cyc first seen.
//   - No re-ack until cyc drops. rdt is valid in the ack cycle, otherwise 0.
//  Register map:
//   adr[2]=0 DATA read : {23'b0, valid, byte}; pops the FIFO in the ack cycle.
//                        Empty FIFO returns 0 and does not pop.
//   adr[2]=0 write     : ignored, acked.
//   adr[2]=1 STATUS read : {29'b0, overrun, frame_err, rx_ready}.
//   adr[2]=1 write       : dat[1]=1 clears frame_err, dat[2]=1 clears overrun.
//                          A set event in the same cycle wins over the clear.
// STRUCTURE
//  - Shared include uart_defs.vh: register offsets, status bit positions, FSM state encodings.
//  - Sub-module uart_rx_fifo (DEPTH param; push/pop/din/dout/empty/full).
//  - Top level holds the synchroniser, FSM and bus decode.
// TESTING  (DEPTH=4, baud16_en=1 every cycle, bit time 16 clocks)
//  1. Frame 0x55, then read DATA -> rdt=0x155, rx_ready 1->0, status=0.
//  2. Frame 0xA3 with stop bit=0 -> STATUS=0x2, FIFO empty; write 0x2 -> STATUS=0.
//  3. rx low 4 ticks then high -> no byte, no error, FSM back in IDLE.
//  4. Frames 0x01..0x05, no reads -> reads 0x101..0x104, 5th read 0, STATUS bit2=1.
//  5. FIFO full, DATA read in the push cycle of 0x06 -> no overrun; 0x06 read last.
//  6. wb_rst asserted mid DATA state -> all outputs reset; next frame 0x7E received intact.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM states, register offsets,
// status bit positions and the status word packer.
package uart_rx_pkg;

  // Receive FSM states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_e;

  // Register select is address bit 2.
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS register bit positions; the same positions clear the flags on write.
  localparam int ST_READY   = 0;
  localparam int ST_FRAME   = 1;
  localparam int ST_OVERRUN = 2;

  // DATA register: bit 8 flags that the low byte holds a received character.
  localparam int DATA_VALID = 8;

  function automatic logic [31:0] status_word(input logic overrun,
                                              input logic frame_err,
                                              input logic ready);
    status_word             = '0;
    status_word[ST_OVERRUN] = overrun;
    status_word[ST_FRAME]   = frame_err;
    status_word[ST_READY]   = ready;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Data bus port of the UART receiver.
// Handshake: the master raises wb_dbus_cyc with adr/we/dat stable and holds
// them until it sees ack; the slave pulses ack for exactly one cycle (read
// data valid on rdt in that cycle only) and will not ack again until cyc has
// been dropped for at least one cycle.
interface uart_rx_if;
  logic [31:0] wb_dbus_adr;
  logic [31:0] wb_dbus_dat;
  logic [3:0]  wb_dbus_sel;
  logic        wb_dbus_we;
  logic        wb_dbus_cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (
    output wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    input  rdt, ack
  );

  modport slave (
    input  wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    output rdt, ack
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO. A push while full is accepted only if a pop
// happens in the same cycle; the caller flags overrun otherwise.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer next-state: both advance independently and wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_rx.sv
// Bus-mapped UART receiver: 16x oversampled 8N1, LSB first. Holds the input
// synchroniser, the receive FSM, the status flags and the bus decode; bytes
// are buffered in uart_rx_fifo.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int                AWIDTH = 8,
  parameter logic [AWIDTH-1:0] ADDR   = '0,
  parameter int                DEPTH  = 4
) (
  input  logic      wb_clk,
  input  logic      wb_rst,
  uart_rx_if.slave  bus,
  input  logic      baud16_en,
  input  logic      rx,
  output logic      rx_ready,
  output logic      rx_err,
  output rx_state_e dbg_state_o
);

  logic      rx_meta_q, rxs_q;
  rx_state_e state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic      push, frame_set, overrun_set;
  logic [7:0] fifo_dout;
  logic      fifo_empty, fifo_full;
  logic      cyc, busy_q, ack_q;
  logic      reg_sel, pop, clr_status;
  logic      frame_err_q, overrun_q;
  logic      unused_bus;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: moves only on oversampling strobes.
  always_comb begin
    state_d = state_q;
    if (baud16_en) begin
      case (state_q)
        S_IDLE:  if (!rxs_q) state_d = S_START;
        S_START: if (tick_q == 4'd7) state_d = rxs_q ? S_IDLE : S_DATA;
        S_DATA:  if (tick_q == 4'd15 && bit_q == 3'd7) state_d = S_STOP;
        S_STOP:  if (tick_q == 4'd15) state_d = rxs_q ? S_IDLE : S_BREAK;
        S_BREAK: if (rxs_q) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: tick/bit counters, data shifter, push and framing-error events.
  // Start bit is checked at its middle (tick 7), then each later bit is
  // sampled 16 ticks on, i.e. also near its middle.
  always_comb begin
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    if (baud16_en) begin
      case (state_q)
        S_IDLE: tick_d = '0;
        S_START: begin
          tick_d = (tick_q == 4'd7) ? 4'd0 : tick_q + 4'd1;
          bit_d  = '0;
        end
        S_DATA: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d[bit_q] = rxs_q;
            bit_d          = bit_q + 3'd1;
          end
        end
        S_STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            push      = rxs_q;
            frame_set = ~rxs_q;
          end
        end
        S_BREAK: tick_d = '0;
        default: tick_d = '0;
      endcase
    end
  end

  // Receive datapath registers.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk_i  (wb_clk),
    .rst_i  (wb_rst),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (shift_q),
    .dout_o (fifo_dout),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  // Bus decode: ack one cycle after cyc is first seen, then hold off until
  // cyc drops so a stalled master cannot pop twice.
  assign cyc     = bus.wb_dbus_cyc & (bus.wb_dbus_adr[31 -: AWIDTH] == ADDR);
  assign reg_sel = bus.wb_dbus_adr[2];

  // Bus acknowledge registers.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      busy_q <= cyc;
      ack_q  <= cyc & ~busy_q;
    end
  end

  assign bus.ack     = ack_q;
  assign pop         = ack_q & ~bus.wb_dbus_we & (reg_sel == REG_DATA);
  assign clr_status  = ack_q &  bus.wb_dbus_we & (reg_sel == REG_STATUS);
  // A push into a full FIFO only survives if the same cycle pops a byte.
  assign overrun_set = push & fifo_full & ~(pop & ~fifo_empty);

  // Read mux, driven only in the ack cycle of a read.
  always_comb begin
    bus.rdt = '0;
    if (ack_q && !bus.wb_dbus_we) begin
      if (reg_sel == REG_STATUS) begin
        bus.rdt = status_word(overrun_q, frame_err_q, ~fifo_empty);
      end else if (!fifo_empty) begin
        bus.rdt             = {24'b0, fifo_dout};
        bus.rdt[DATA_VALID] = 1'b1;
      end
    end
  end

  // Sticky error flags; a set event in the same cycle beats a bus clear.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set |
                     (frame_err_q & ~(clr_status & bus.wb_dbus_dat[ST_FRAME]));
      overrun_q   <= overrun_set |
                     (overrun_q & ~(clr_status & bus.wb_dbus_dat[ST_OVERRUN]));
    end
  end

  assign rx_ready    = ~fifo_empty;
  assign rx_err      = overrun_q | frame_err_q;
  assign dbg_state_o = state_q;

  // Byte selects and most address/data bits carry no meaning for this block.
  assign unused_bus = ^{bus.wb_dbus_sel, bus.wb_dbus_dat, bus.wb_dbus_adr};

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames, checked
// against a queue-based model of the receive buffer and flags.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int         DEPTH = 4;
  localparam logic [7:0] CS    = 8'h40;

  logic      clk       = 1'b0;
  logic      rst       = 1'b1;
  logic      baud16_en = 1'b1;
  logic      rx        = 1'b1;
  logic      rx_ready;
  logic      rx_err;
  rx_state_e dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  model_q[$];
  logic        m_ov = 1'b0;
  logic        m_fe = 1'b0;

  uart_rx_if bus();

  uart_rx #(
    .AWIDTH(8),
    .ADDR  (CS),
    .DEPTH (DEPTH)
  ) dut (
    .wb_clk     (clk),
    .wb_rst     (rst),
    .bus        (bus),
    .baud16_en  (baud16_en),
    .rx         (rx),
    .rx_ready   (rx_ready),
    .rx_err     (rx_err),
    .dbg_state_o(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: every read ack pops one expectation; rdt must be 0 outside ack.
  always @(posedge clk) begin
    #1;
    if (bus.ack && !bus.wb_dbus_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rdt_unexpected: read ack with rdt=%h and nothing expected", bus.rdt);
      end else begin
        chk("rdt", bus.rdt, exp_q.pop_front());
      end
    end else if (bus.wb_dbus_cyc && !bus.ack) begin
      chk("rdt_idle", bus.rdt, 32'h0);
    end
  end

  // Driver: one bus access, then hold cyc two more cycles to check no re-ack.
  task automatic bus_xfer(input logic sel_status, input logic we, input logic [31:0] dat,
                          input logic [7:0] cs);
    int n;
    @(negedge clk);
    bus.wb_dbus_adr = {cs, 21'b0, sel_status, 2'b00};
    bus.wb_dbus_dat = dat;
    bus.wb_dbus_we  = we;
    bus.wb_dbus_cyc = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.ack && n < 8);
    if (cs == CS) chk("ack_seen", {31'b0, bus.ack}, 32'd1);
    else          chk("ack_foreign_cs", {31'b0, bus.ack}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("ack_single", {31'b0, bus.ack}, 32'd0);
    end
    @(negedge clk);
    bus.wb_dbus_cyc = 1'b0;
    bus.wb_dbus_we  = 1'b0;
  endtask

  task automatic read_data();
    logic [31:0] e;
    e = 32'h0;
    if (model_q.size() != 0) e = {23'b0, 1'b1, model_q.pop_front()};
    exp_q.push_back(e);
    bus_xfer(REG_DATA, 1'b0, 32'h0, CS);
  endtask

  task automatic read_status();
    exp_q.push_back({29'b0, m_ov, m_fe, model_q.size() != 0});
    bus_xfer(REG_STATUS, 1'b0, 32'h0, CS);
  endtask

  task automatic write_status(input logic [31:0] dat);
    if (dat[1]) m_fe = 1'b0;
    if (dat[2]) m_ov = 1'b0;
    bus_xfer(REG_STATUS, 1'b1, dat, CS);
  endtask

  // Driver: one serial frame, 16 clocks per bit, then an idle gap.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk);
    if (!stop_bit)                   m_fe = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else                             m_ov = 1'b1;
  endtask

  task automatic chk_pins(input string tag);
    chk({tag, "_rx_ready"}, {31'b0, rx_ready}, {31'b0, model_q.size() != 0});
    chk({tag, "_rx_err"},   {31'b0, rx_err},   {31'b0, m_ov | m_fe});
  endtask

  // Stimulus.
  initial begin
    bus.wb_dbus_adr = '0;
    bus.wb_dbus_dat = '0;
    bus.wb_dbus_sel = 4'hF;
    bus.wb_dbus_we  = 1'b0;
    bus.wb_dbus_cyc = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("rst_rx_err",   {31'b0, rx_err},   32'd0);
    chk("rst_ack",      {31'b0, bus.ack},  32'd0);
    chk("rst_rdt",      bus.rdt,           32'd0);
    chk("rst_state",    {29'b0, dbg_state}, {29'b0, S_IDLE});
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single frame, read it back; DATA write ignored; foreign select.
    send_frame(8'h55, 1'b1, 20);
    chk_pins("t1");
    read_data();
    chk_pins("t1_after");
    read_status();
    bus_xfer(REG_DATA, 1'b1, 32'hFF, CS);
    read_status();
    bus_xfer(REG_DATA, 1'b0, 32'h0, 8'h41);

    // 2: framing error, then clear.
    send_frame(8'hA3, 1'b0, 20);
    chk_pins("t2");
    read_status();
    write_status(32'h2);
    read_status();

    // 3: short low glitch is rejected.
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
    chk_pins("t3");
    read_status();

    // 4: overrun on the fifth unread frame.
    for (int i = 1; i <= 5; i++) send_frame(i[7:0], 1'b1, 20);
    chk_pins("t4");
    for (int i = 0; i < 5; i++) read_data();
    read_status();
    write_status(32'h4);
    read_status();

    // 5: full FIFO, DATA read lands in the push cycle of 0x06.
    for (int i = 1; i <= 4; i++) send_frame(i[7:0], 1'b1, 20);
    fork
      send_frame(8'h06, 1'b1, 24);
      begin
        int n;
        n = 0;
        do begin
          @(posedge clk);
          #1;
          n++;
        end while (dbg_state != S_STOP && n < 400);
        chk("t5_stop_reached", {31'b0, dbg_state == S_STOP}, 32'd1);
        repeat (14) @(posedge clk);
        read_data();
      end
    join
    chk_pins("t5");
    for (int i = 0; i < 4; i++) read_data();
    read_status();

    // 6: reset mid DATA with a buffered byte and an error pending.
    send_frame(8'h33, 1'b1, 20);
    send_frame(8'h11, 1'b0, 20);
    chk_pins("t6_pre");
    @(negedge clk);
    rx = 1'b0;
    repeat (16 + 48) @(negedge clk);
    chk("t6_in_data", {29'b0, dbg_state}, {29'b0, S_DATA});
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    m_ov = 1'b0;
    m_fe = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
    chk("t6_ack",   {31'b0, bus.ack},   32'd0);
    chk("t6_rdt",   bus.rdt,            32'd0);
    chk_pins("t6_post");
    send_frame(8'h7E, 1'b1, 20);
    read_data();
    read_status();

    // Randomized frames, reads and flag clears.
    for (int it = 0; it < 16; it++) begin
      logic [7:0] b;
      logic       sb;
      int         nr;
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 9) != 0);
      send_frame(b, sb, 16 + int'($urandom_range(0, 20)));
      chk_pins("rnd");
      nr = int'($urandom_range(0, 2));
      for (int r = 0; r < nr; r++) read_data();
      if ($urandom_range(0, 3) == 0) read_status();
      if ((m_ov | m_fe) && $urandom_range(0, 1) == 1)
        write_status({29'b0, 2'($urandom_range(0, 3)), 1'b0});
    end
    read_status();

    repeat (4) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
